// File: rtl/float_to_int.sv
// float_to_int: converts an IEEE-754 single-precision operand into a signed
// 32-bit integer, truncating toward zero. The magnitude is aligned by an
// iterative right shifter, one bit per cycle, so latency depends on the
// operand exponent.
//
// Handshake (both sides): a transfer happens on a rising edge where the
// producer's strobe and the consumer's ack are both high. f2i_a_ack is raised
// only while idle in GET. f2i_z_stb is raised with f2i_z and both stay stable
// until the edge where f2i_z_ack is sampled high.
module float_to_int #(
    parameter logic [31:0] OVF_VALUE = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] f2i_a,
    input  logic        f2i_a_stb,
    output logic        f2i_a_ack,
    output logic [31:0] f2i_z,
    output logic        f2i_z_stb,
    input  logic        f2i_z_ack
);

    typedef enum logic [2:0] {
        GET     = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        CONVERT = 3'd3,
        PACK    = 3'd4,
        PUT     = 3'd5
    } state_t;

    state_t             state;
    logic [31:0]        a_reg;
    logic               s;
    logic signed [9:0]  e;
    logic [31:0]        m;

    // Single-process FSM: handshakes, unpacking, alignment shifter and packing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GET;
            a_reg     <= 32'd0;
            s         <= 1'b0;
            e         <= 10'sd0;
            m         <= 32'd0;
            f2i_a_ack <= 1'b0;
            f2i_z     <= 32'd0;
            f2i_z_stb <= 1'b0;
        end else begin
            case (state)
                GET: begin
                    if (f2i_a_ack && f2i_a_stb) begin
                        a_reg     <= f2i_a;
                        f2i_a_ack <= 1'b0;
                        state     <= UNPACK;
                    end else begin
                        f2i_a_ack <= 1'b1;
                    end
                end

                UNPACK: begin
                    s     <= a_reg[31];
                    e     <= $signed({2'b00, a_reg[30:23]}) - 10'sd127;
                    m     <= {1'b1, a_reg[22:0], 8'b0};
                    state <= SPECIAL;
                end

                SPECIAL: begin
                    if ((e == 10'sd128) || (e >= 10'sd31)) begin
                        // inf, NaN and every magnitude >= 2^31 (including -2^31)
                        f2i_z     <= OVF_VALUE;
                        f2i_z_stb <= 1'b1;
                        state     <= PUT;
                    end else if (e < 10'sd0) begin
                        // |x| < 1.0, zero and denormals all truncate to 0
                        f2i_z     <= 32'd0;
                        f2i_z_stb <= 1'b1;
                        state     <= PUT;
                    end else begin
                        state <= CONVERT;
                    end
                end

                CONVERT: begin
                    // The edge that brings e to 31 also leaves for PACK, so
                    // an exponent of e costs exactly 31-e shift cycles.
                    m <= m >> 1;
                    e <= e + 10'sd1;
                    if (e == 10'sd30) begin
                        state <= PACK;
                    end
                end

                PACK: begin
                    f2i_z     <= s ? (~m + 32'd1) : m;
                    f2i_z_stb <= 1'b1;
                    state     <= PUT;
                end

                PUT: begin
                    if (f2i_z_ack) begin
                        f2i_z_stb <= 1'b0;
                        state     <= GET;
                    end
                end

                default: begin
                    state <= GET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed, table-driven bench for float_to_int.
module tb_float_to_int;

    logic        clk;
    logic        rst_n;
    logic [31:0] f2i_a;
    logic        f2i_a_stb;
    logic        f2i_a_ack;
    logic [31:0] f2i_z;
    logic        f2i_z_stb;
    logic        f2i_z_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        int          lat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    logic [31:0] exp_q[$];

    float_to_int dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f2i_a     (f2i_a),
        .f2i_a_stb (f2i_a_stb),
        .f2i_a_ack (f2i_a_ack),
        .f2i_z     (f2i_z),
        .f2i_z_stb (f2i_z_stb),
        .f2i_z_ack (f2i_z_ack)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one operand, check result, latency, optional hold, and ack reassert.
    task automatic run_op(input logic [31:0] a, input logic [31:0] exp_z,
                          input int exp_lat, input int hold);
        int n;
        bit ok;
        @(negedge clk);
        f2i_a     = a;
        f2i_a_stb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (f2i_a_ack) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'd1, 32'd0);
            f2i_a_stb = 1'b0;
            return;
        end
        @(posedge clk);
        #1 f2i_a_stb = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (f2i_z_stb) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("result_timeout", 32'd1, 32'd0);
            return;
        end
        check($sformatf("latency[%h]", a), n, exp_lat);
        check($sformatf("z[%h]", a), f2i_z, exp_z);
        for (int i = 0; i < hold; i++) begin
            f2i_a_stb = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_z_stb", {31'd0, f2i_z_stb}, 32'd1);
            check("hold_z", f2i_z, exp_z);
            check("hold_a_ack", {31'd0, f2i_a_ack}, 32'd0);
        end
        f2i_a_stb = 1'b0;
        f2i_z_ack = 1'b1;
        @(posedge clk);
        #1 f2i_z_ack = 1'b0;
        @(negedge clk);
        check("post_hs_z_stb", {31'd0, f2i_z_stb}, 32'd0);
        check("post_hs_a_ack_low", {31'd0, f2i_a_ack}, 32'd0);
        @(negedge clk);
        check("post_hs_a_ack_high", {31'd0, f2i_a_ack}, 32'd1);
    endtask

    // Back-to-back stream: stb and z_ack held high, scoreboard in order.
    task automatic run_stream();
        int  idx, done, hs_c;
        bit  pending, acc, hs;
        idx = 0; done = 0; hs_c = 0; pending = 1'b0;
        @(negedge clk);
        f2i_a     = vecs[0].a;
        f2i_a_stb = 1'b1;
        f2i_z_ack = 1'b1;
        for (int cyc = 0; cyc < 2000 && done < NVEC; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (pending && cyc == hs_c + 1)
                check("stream_a_ack_low", {31'd0, f2i_a_ack}, 32'd0);
            if (pending && cyc == hs_c + 2) begin
                check("stream_a_ack_high", {31'd0, f2i_a_ack}, 32'd1);
                pending = 1'b0;
            end
            acc = f2i_a_ack && f2i_a_stb && (idx < NVEC);
            hs  = f2i_z_stb;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_result", f2i_z, 32'hxxxxxxxx);
                end else begin
                    check($sformatf("stream_z[%0d]", done), f2i_z, exp_q.pop_front());
                end
                done++;
                hs_c    = cyc;
                pending = 1'b1;
            end
            if (acc) exp_q.push_back(vecs[idx].z);
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < NVEC) f2i_a = vecs[idx].a;
                else f2i_a_stb = 1'b0;
            end
        end
        check("stream_count", done, NVEC);
        f2i_a_stb = 1'b0;
        f2i_z_ack = 1'b0;
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{32'h3F800000, 32'h00000001, 35};  // 1.0
        vecs[1]  = '{32'h40200000, 32'h00000002, 34};  // 2.5
        vecs[2]  = '{32'hC0700000, 32'hFFFFFFFD, 34};  // -3.75
        vecs[3]  = '{32'h3F000000, 32'h00000000, 3};   // 0.5
        vecs[4]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 5};   // max in range
        vecs[5]  = '{32'h4F000000, 32'h80000000, 3};   // 2^31
        vecs[6]  = '{32'hCF000000, 32'h80000000, 3};   // -2^31
        vecs[7]  = '{32'h7F800000, 32'h80000000, 3};   // +inf
        vecs[8]  = '{32'h7FC00000, 32'h80000000, 3};   // NaN
        vecs[9]  = '{32'h80000000, 32'h00000000, 3};   // -0.0
        vecs[10] = '{32'h00000001, 32'h00000000, 3};   // denormal
        vecs[11] = '{32'hC2F6E979, 32'hFFFFFF85, 29};  // -123.456
        vecs[12] = '{32'h4B000001, 32'h00800001, 12};  // 8388609.0
        vecs[13] = '{32'h3FFFFFFF, 32'h00000001, 35};  // 1.9999999

        // Reset
        rst_n     = 1'b0;
        f2i_a     = 32'd0;
        f2i_a_stb = 1'b0;
        f2i_z_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a_ack", {31'd0, f2i_a_ack}, 32'd0);
        check("reset_z_stb", {31'd0, f2i_z_stb}, 32'd0);
        check("reset_z", f2i_z, 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].a, vecs[i].z, vecs[i].lat, 0);

        // Result held while downstream stalls; new strobes ignored
        run_op(32'h40200000, 32'h00000002, 34, 20);

        // Reset during CONVERT discards the in-flight operand
        @(negedge clk);
        f2i_a     = 32'h3F800000;
        f2i_a_stb = 1'b1;
        @(posedge clk);
        #1 f2i_a_stb = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_a_ack", {31'd0, f2i_a_ack}, 32'd0);
        check("midreset_z_stb", {31'd0, f2i_z_stb}, 32'd0);
        check("midreset_z", f2i_z, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (f2i_z_stb) seen = 1'b1;
        end
        check("midreset_no_result", {31'd0, seen}, 32'd0);
        run_op(32'hC0700000, 32'hFFFFFFFD, 34, 0);

        // Back-to-back stream
        run_stream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
